// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, IF/ID register, stall/redirect/halt control.
// Optional FETCH_PERF_CNT_EN adds saturating fetch and bubble counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic        advance, bubble;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        misalign_d = 1'b0;
        advance    = 1'b0;
        bubble     = 1'b0;
        case (state_q)
            ST_RUN: begin
                // Redirect wins over halt and stall: the wrong-path fetch must be squashed.
                if (redirect_valid) begin
                    pc_d       = redirect_target & ~32'h3;
                    misalign_d = (redirect_target[1:0] != 2'b00);
                    bubble     = 1'b1;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                    bubble  = 1'b1;
                end else if (!stall) begin
                    advance = 1'b1;
                    pc_d    = pc_plus4;
                    instr_d = imem_instr;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        if (bubble) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc4_q      <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr    = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;
    assign halted       = (state_q == ST_HALT);
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (advance && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    assign imem_instr = mem[imem_addr[7:2]];

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .imem_instr      (imem_instr),
        .imem_addr       (imem_addr),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .misalign_err    (misalign_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted, m_mis;
    logic [31:0] m_fcnt, m_bcnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = 0; m_valid = 0;
            m_halted = 0; m_mis = 0; m_fcnt = 0; m_bcnt = 0;
        end else begin
            m_mis = 0;
            if (!m_halted) begin
                if (redirect_valid) begin
                    m_pc = {redirect_target[31:2], 2'b00};
                    m_instr = NOP_INSTR; m_pc4 = 0; m_valid = 0;
                    m_mis = (redirect_target % 4) != 0;
                    if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
                end else if (halt_req) begin
                    m_instr = NOP_INSTR; m_pc4 = 0; m_valid = 0;
                    m_halted = 1;
                    if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
                end else if (!stall) begin
                    m_instr = mem[(m_pc / 4) % 64];
                    m_pc = m_pc + 4;
                    m_pc4 = m_pc;
                    m_valid = 1;
                    if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".pc"}, imem_addr, m_pc);
        check_val({tag, ".instr"}, if_id_instr, m_instr);
        check_val({tag, ".pc4"}, if_id_pc4, m_pc4);
        check_val({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check_val({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
        check_val({tag, ".mis"}, {31'd0, misalign_err}, {31'd0, m_mis});
`ifdef FETCH_PERF_CNT_EN
        check_val({tag, ".fcnt"}, perf_fetch_cnt, m_fcnt);
        check_val({tag, ".bcnt"}, perf_bubble_cnt, m_bcnt);
`endif
    endtask

    task automatic step(input string tag, input logic rst, input logic stl, input logic rv,
                        input logic [31:0] tgt, input logic hr);
        reset = rst; stall = stl; redirect_valid = rv; redirect_target = tgt; halt_req = hr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h20090064;
        mem[1] = 32'h200a00c8;
        mem[2] = 32'h012a5820;
        reset = 1; stall = 0; redirect_valid = 0; redirect_target = 0; halt_req = 0;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0; m_mis = 0;
        m_fcnt = 0; m_bcnt = 0;
        #2;

        step("rst", 1, 0, 0, 0, 0);
        check_val("rst_pc", imem_addr, RESET_PC);
        check_val("rst_valid", {31'd0, if_id_valid}, 32'd0);

        step("adv0", 0, 0, 0, 0, 0);
        check_val("seq0", if_id_instr, 32'h20090064);
        check_val("seq0_pc4", if_id_pc4, 32'd4);
        step("adv1", 0, 0, 0, 0, 0);
        check_val("seq1", if_id_instr, 32'h200a00c8);
        check_val("pc_at_stall", imem_addr, 32'd8);
        step("stall0", 0, 1, 0, 0, 0);
        step("stall1", 0, 1, 0, 0, 0);
        check_val("stall_pc", imem_addr, 32'd8);
        check_val("stall_instr", if_id_instr, 32'h200a00c8);
        step("adv2", 0, 0, 0, 0, 0);
        check_val("seq2", if_id_instr, 32'h012a5820);
        check_val("seq2_pc4", if_id_pc4, 32'd12);
        check_val("release_pc", imem_addr, 32'd12);

        step("redir_stall", 0, 1, 1, 32'h40, 0);
        check_val("redir_pc", imem_addr, 32'h40);
        check_val("redir_instr", if_id_instr, NOP_INSTR);
        step("after_redir", 0, 0, 0, 0, 0);
        check_val("fetch_m16", if_id_instr, mem[16]);

`ifdef FETCH_PERF_CNT_EN
        check_val("perf_fetch_s13", perf_fetch_cnt, 32'd4);
        check_val("perf_bubble_s13", perf_bubble_cnt, 32'd1);
`endif

        step("misalign", 0, 0, 1, 32'h43, 0);
        check_val("mis_pc", imem_addr, 32'h40);
        check_val("mis_on", {31'd0, misalign_err}, 32'd1);
        step("mis_clear", 0, 0, 0, 0, 0);
        check_val("mis_off", {31'd0, misalign_err}, 32'd0);

        step("to_top", 0, 0, 1, 32'hFFFF_FFFC, 0);
        step("wrap", 0, 0, 0, 0, 0);
        check_val("wrap_pc", imem_addr, 32'd0);
        step("halt", 0, 0, 0, 0, 1);
        check_val("halted_on", {31'd0, halted}, 32'd1);
        step("halt_redir", 0, 0, 1, 32'h80, 0);
        check_val("halt_pc_frozen", imem_addr, 32'd0);
        step("halt_free", 0, 0, 0, 0, 0);
        step("halt_rst", 1, 0, 0, 0, 0);
        check_val("rst_halted", {31'd0, halted}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic rs, st, rv, hr;
            logic [31:0] tg;
            rs = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 5) == 0);
            hr = ($urandom_range(0, 49) == 0);
            tg = ($urandom_range(0, 1) == 0) ? {24'd0, 8'($urandom)} : $urandom;
            step("rnd", rs, st, rv, tg, hr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
